// File: rtl/video_axis_pkg.sv
// Shared widths, field positions and the FIFO entry layout for the video-to-AXIS slice.
package video_axis_pkg;

   localparam int unsigned PIX_W    = 24;
   localparam int unsigned ENTRY_W  = 26;
   localparam int unsigned USER_BIT = 25;
   localparam int unsigned LAST_BIT = 24;

   typedef struct packed {
      logic             user;
      logic             last;
      logic [PIX_W-1:0] data;
   } pix_entry_t;

endpackage

// File: rtl/axis_fifo_sync.sv
// Single-clock first-word-fall-through FIFO; the head is visible on data_o while not empty,
// and the last popped word is held while empty so the output never shows stale storage.
module axis_fifo_sync #(
   parameter int unsigned Width = 26,
   parameter int unsigned Depth = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [Width-1:0]         data_i,
   input  logic                     pop_i,
   output logic [Width-1:0]         data_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic [Width-1:0] hold_q;
   logic             full, empty, push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(Depth));
   assign pop_ok  = pop_i && !empty;
   // A push at full is accepted only when the head leaves in the same cycle.
   assign push_ok = push_i && (!full || pop_ok);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + (AW+1)'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
      end else begin
         count_q <= count_d;
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            hold_q   <= mem_q[rd_ptr_q];
         end
      end
   end

   assign data_o  = empty ? hold_q : mem_q[rd_ptr_q];
   assign empty_o = empty;
   assign count_o = count_q;

endmodule

// File: rtl/video_to_axis.sv
// Parallel DE/VSYNC/RGB pixel stream to AXI4-Stream video with tuser/tlast framing and a FIFO.
// Optional geometry checking is enabled by defining VIDEO_TO_AXIS_GEOM_CHECK_EN.
module video_to_axis
   import video_axis_pkg::*;
#(
   parameter int unsigned IMG_W      = 64,
   parameter int unsigned IMG_H      = 64,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic             s_axis_video_aclk,
   input  logic             s_axis_video_aresetn,
   input  logic             VIDEO_IN_de,
   input  logic             VIDEO_IN_vsync,
   input  logic [PIX_W-1:0] VIDEO_IN_data,
   output logic [PIX_W-1:0] VIDEO_OUT_tdata,
   output logic             VIDEO_OUT_tvalid,
   input  logic             VIDEO_OUT_tready,
   output logic             VIDEO_OUT_tuser,
   output logic             VIDEO_OUT_tlast,
   output logic             overflow,
   output logic             geom_err
);

   localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   logic [CW-1:0]      col_q, col_d, eff_col;
   logic [RW-1:0]      row_q, row_d, eff_row;
   logic               sof_q, sof_d;
   logic               ovf_q, ovf_d;
   pix_entry_t         wr_entry;
   logic [ENTRY_W-1:0] head;
   logic [CntW-1:0]    fifo_count;
   logic               fifo_empty, fifo_full, pop;

   assign fifo_full = (fifo_count == CntW'(FIFO_DEPTH));
   assign pop       = !fifo_empty && VIDEO_OUT_tready;

   // Vsync takes effect before a coincident pixel, so that pixel becomes (0,0) of the new frame.
   always_comb begin
      eff_col       = VIDEO_IN_vsync ? '0 : col_q;
      eff_row       = VIDEO_IN_vsync ? '0 : row_q;
      wr_entry.user = VIDEO_IN_vsync | sof_q;
      wr_entry.last = (eff_col == CW'(IMG_W - 1));
      wr_entry.data = VIDEO_IN_data;
      col_d         = eff_col;
      row_d         = eff_row;
      sof_d         = VIDEO_IN_vsync | sof_q;
      if (VIDEO_IN_de) begin
         sof_d = 1'b0;
         if (eff_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + RW'(1);
         end else begin
            col_d = eff_col + CW'(1);
         end
      end
      ovf_d = ovf_q | (VIDEO_IN_de && fifo_full && !pop);
   end

   always_ff @(posedge s_axis_video_aclk or negedge s_axis_video_aresetn) begin
      if (!s_axis_video_aresetn) begin
         col_q <= '0;
         row_q <= '0;
         sof_q <= 1'b1;
         ovf_q <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         sof_q <= sof_d;
         ovf_q <= ovf_d;
      end
   end

   axis_fifo_sync #(
      .Width (ENTRY_W),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (s_axis_video_aclk),
      .rst_ni  (s_axis_video_aresetn),
      .push_i  (VIDEO_IN_de),
      .data_i  (wr_entry),
      .pop_i   (pop),
      .data_o  (head),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign VIDEO_OUT_tvalid = !fifo_empty;
   assign VIDEO_OUT_tdata  = head[PIX_W-1:0];
   assign VIDEO_OUT_tuser  = head[USER_BIT];
   assign VIDEO_OUT_tlast  = head[LAST_BIT];
   assign overflow         = ovf_q;

`ifdef VIDEO_TO_AXIS_GEOM_CHECK_EN
   logic de_q, vs_seen_q, gerr_q, gerr_d;

   // The first vsync after reset only marks that frame boundaries are now known.
   always_comb begin
      gerr_d = gerr_q
             | (de_q && !VIDEO_IN_de && (col_q != '0))
             | (VIDEO_IN_vsync && vs_seen_q && ((col_q != '0) || (row_q != '0)));
   end

   always_ff @(posedge s_axis_video_aclk or negedge s_axis_video_aresetn) begin
      if (!s_axis_video_aresetn) begin
         de_q      <= 1'b0;
         vs_seen_q <= 1'b0;
         gerr_q    <= 1'b0;
      end else begin
         de_q      <= VIDEO_IN_de;
         vs_seen_q <= vs_seen_q | VIDEO_IN_vsync;
         gerr_q    <= gerr_d;
      end
   end

   assign geom_err = gerr_q;
`else
   assign geom_err = 1'b0;
`endif

endmodule

// File: tb/tb_video_to_axis.sv
// Directed bench for video_to_axis with a queue-based reference model checked every cycle.
module tb_video_to_axis;

   localparam int W = 64;
   localparam int H = 64;
   localparam int D = 16;

`ifdef VIDEO_TO_AXIS_GEOM_CHECK_EN
   localparam bit GeomEn = 1'b1;
`else
   localparam bit GeomEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        de = 1'b0, vs = 1'b0, rdy = 1'b0;
   logic [23:0] din = '0;
   logic [23:0] tdata;
   logic        tvalid, tuser, tlast, ovf, gerr;

   always #5 clk = ~clk;

   video_to_axis #(
      .IMG_W      (W),
      .IMG_H      (H),
      .FIFO_DEPTH (D)
   ) dut (
      .s_axis_video_aclk    (clk),
      .s_axis_video_aresetn (rstn),
      .VIDEO_IN_de          (de),
      .VIDEO_IN_vsync       (vs),
      .VIDEO_IN_data        (din),
      .VIDEO_OUT_tdata      (tdata),
      .VIDEO_OUT_tvalid     (tvalid),
      .VIDEO_OUT_tready     (rdy),
      .VIDEO_OUT_tuser      (tuser),
      .VIDEO_OUT_tlast      (tlast),
      .overflow             (ovf),
      .geom_err             (gerr)
   );

   typedef struct packed {
      bit        user;
      bit        last;
      bit [23:0] data;
   } ent_t;

   ent_t q[$];
   int   m_col, m_row;
   bit   m_sof, m_ovf, m_gerr, m_vs_seen, m_prev_de;
   int   errs = 0, checks = 0;
   int   pops, tuser_cnt, tlast_cnt, drops;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] pix(input int f, input int r, input int c);
      return {8'(f), 8'(r), 8'(c)};
   endfunction

   task automatic model_clear();
      q.delete();
      m_col = 0; m_row = 0; m_sof = 1; m_ovf = 0; m_gerr = 0; m_vs_seen = 0; m_prev_de = 0;
   endtask

   task automatic reset_counts();
      pops = 0; tuser_cnt = 0; tlast_cnt = 0; drops = 0;
   endtask

   // One clock edge of the specified behaviour, using the inputs sampled at that edge.
   task automatic model_step();
      bit   do_pop;
      ent_t e;
      do_pop = (q.size() > 0) && rdy;
      if (GeomEn) begin
         if (m_prev_de && !de && m_col != 0) m_gerr = 1;
         if (vs && m_vs_seen && (m_col != 0 || m_row != 0)) m_gerr = 1;
      end
      if (vs) begin
         m_vs_seen = 1; m_col = 0; m_row = 0; m_sof = 1;
      end
      if (do_pop) begin
         e = q.pop_front();
         pops++;
         tuser_cnt += int'(e.user);
         tlast_cnt += int'(e.last);
      end
      if (de) begin
         e.user = m_sof;
         e.last = (m_col == W - 1);
         e.data = din;
         m_sof  = 0;
         if (q.size() < D) q.push_back(e);
         else begin
            m_ovf = 1;
            drops++;
         end
         m_col++;
         if (m_col == W) begin
            m_col = 0;
            m_row = (m_row + 1) % H;
         end
      end
      m_prev_de = de;
   endtask

   task automatic compare();
      chk("tvalid", 32'(tvalid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         chk("tdata", 32'(tdata), 32'(q[0].data));
         chk("tuser", 32'(tuser), 32'(q[0].user));
         chk("tlast", 32'(tlast), 32'(q[0].last));
      end else begin
         chk("tdata_known", 32'($isunknown({tdata, tuser, tlast})), 32'(0));
      end
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("geom_err", 32'(gerr), 32'(m_gerr));
   endtask

   task automatic cyc(input bit d, input bit v, input logic [23:0] x, input bit r);
      de = d; vs = v; din = x; rdy = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 24'h0, r);
   endtask

   // Reset lands mid-cycle; outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      de = 0; vs = 0; rdy = 0;
      #2 rstn = 1'b0;
      #1;
      chk("rst_tvalid", 32'(tvalid), 32'(0));
      chk("rst_tdata", 32'(tdata), 32'(0));
      chk("rst_tuser", 32'(tuser), 32'(0));
      chk("rst_tlast", 32'(tlast), 32'(0));
      chk("rst_overflow", 32'(ovf), 32'(0));
      chk("rst_geom_err", 32'(gerr), 32'(0));
      model_clear();
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      compare();
   endtask

   initial begin
      model_clear();
      reset_counts();
      @(negedge clk);
      do_reset();

      // Basic frame.
      cyc(1'b0, 1'b1, 24'h0, 1'b1);
      idle(1, 1'b1);
      reset_counts();
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) cyc(1'b1, 1'b0, pix(1, r, c), 1'b1);
         idle(16, 1'b1);
      end
      idle(4, 1'b1);
      chk("frame_beats", 32'(pops), 32'(4096));
      chk("frame_tuser_cnt", 32'(tuser_cnt), 32'(1));
      chk("frame_tlast_cnt", 32'(tlast_cnt), 32'(64));
      chk("frame_overflow", 32'(ovf), 32'(0));

      // Back-pressure: 20 stalled pixels, 16 kept, 4 dropped.
      cyc(1'b0, 1'b1, 24'h0, 1'b1);
      idle(1, 1'b1);
      reset_counts();
      for (int c = 0; c < 20; c++) cyc(1'b1, 1'b0, pix(2, 0, c), 1'b0);
      chk("bp_drops", 32'(drops), 32'(4));
      chk("bp_overflow", 32'(ovf), 32'(1));
      chk("bp_head_data", 32'(tdata), 32'(pix(2, 0, 0)));
      chk("bp_head_tuser", 32'(tuser), 32'(1));
      for (int c = 20; c < W; c++) cyc(1'b1, 1'b0, pix(2, 0, c), 1'b1);
      idle(20, 1'b1);
      chk("bp_beats", 32'(pops), 32'(60));
      do_reset();

      // Full FIFO with simultaneous push and pop.
      cyc(1'b0, 1'b1, 24'h0, 1'b1);
      idle(1, 1'b1);
      reset_counts();
      for (int c = 0; c < D; c++) cyc(1'b1, 1'b0, pix(3, 0, c), 1'b0);
      chk("full_tvalid", 32'(tvalid), 32'(1));
      for (int c = D; c < W; c++) cyc(1'b1, 1'b0, pix(3, 0, c), 1'b1);
      chk("full_overflow", 32'(ovf), 32'(0));
      chk("full_drops", 32'(drops), 32'(0));
      idle(20, 1'b1);
      chk("full_beats", 32'(pops), 32'(64));
      do_reset();

      // Vsync after 10 lines, then a fresh frame line.
      cyc(1'b0, 1'b1, 24'h0, 1'b1);
      idle(1, 1'b1);
      reset_counts();
      for (int r = 0; r < 10; r++) begin
         for (int c = 0; c < W; c++) cyc(1'b1, 1'b0, pix(4, r, c), 1'b1);
         idle(16, 1'b1);
      end
      cyc(1'b0, 1'b1, 24'h0, 1'b1);
      idle(1, 1'b1);
      for (int c = 0; c < W; c++) cyc(1'b1, 1'b0, pix(5, 0, c), 1'b1);
      idle(4, 1'b1);
      chk("vs_tuser_cnt", 32'(tuser_cnt), 32'(2));
      chk("vs_tlast_cnt", 32'(tlast_cnt), 32'(11));
      chk("vs_geom_err", 32'(gerr), 32'(GeomEn));

      // Async reset with 5 beats queued.
      do_reset();
      for (int c = 0; c < 5; c++) cyc(1'b1, 1'b0, pix(6, 0, c), 1'b0);
      chk("pre_rst_tvalid", 32'(tvalid), 32'(1));
      do_reset();
      cyc(1'b1, 1'b0, pix(7, 0, 0), 1'b0);
      chk("post_rst_tuser", 32'(tuser), 32'(1));
      chk("post_rst_tdata", 32'(tdata), 32'(pix(7, 0, 0)));
      idle(2, 1'b1);

      // Short line of 40 pixels.
      cyc(1'b0, 1'b1, 24'h0, 1'b1);
      idle(1, 1'b1);
      reset_counts();
      for (int c = 0; c < 40; c++) cyc(1'b1, 1'b0, pix(8, 0, c), 1'b1);
      idle(5, 1'b1);
      chk("short_geom_err", 32'(gerr), 32'(GeomEn));
      chk("short_tlast_cnt", 32'(tlast_cnt), 32'(0));
      chk("short_beats", 32'(pops), 32'(40));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/video_to_axis.md
# video_to_axis

Converts a parallel HDMI-style pixel stream (data enable, vsync, 24-bit RGB) into an AXI4-Stream video stream. It marks start-of-frame on `tuser` and end-of-line on `tlast`, and buffers pixels in a small FIFO to absorb downstream back-pressure. It is the stage directly upstream of the AXI4-Stream video output/logger in the HDMI processing chain, and drives its `VIDEO_OUT_*` port set.

## Interface
- `IMG_W`, default 64: active pixels per line.
- `IMG_H`, default 64: active lines per frame.
- `FIFO_DEPTH`, default 16: FIFO entries; must be a power of 2, ≥ 4.

Ports:
- `s_axis_video_aclk`  in  1  single clock for the whole block.
- `s_axis_video_aresetn`  in  1  asynchronous, active-low reset.
- `VIDEO_IN_de`  in  1  pixel valid (active pixel).
- `VIDEO_IN_vsync`  in  1  vertical sync, active high.
- `VIDEO_IN_data`  in  24  RGB pixel, R in [23:16].
- `VIDEO_OUT_tdata`  out  24  pixel.
- `VIDEO_OUT_tvalid`  out  1  FIFO not empty.
- `VIDEO_OUT_tready`  in  1  sink ready.
- `VIDEO_OUT_tuser`  out  1  first pixel of frame.
- `VIDEO_OUT_tlast`  out  1  last pixel of line.
- `overflow`  out  1  sticky: a pixel was dropped because the FIFO was full.
- `geom_err`  out  1  sticky geometry error (see Configuration).

## Operation
- **Counters:** `col` (0..IMG_W-1) and `row` (0..IMG_H-1), widths `$clog2`. Each pixel with `de`=1 increments `col`. At `col`=IMG_W-1, `col` wraps to 0 and `row` increments; `row` wraps to 0 after IMG_H-1.
- **Frame sync:** any cycle with `vsync`=1 clears `col` and `row` and sets `sof_pending`.
  - The first `de` pixel with `sof_pending`=1 is written with `tuser`=1, and `sof_pending` clears.
  - `vsync`=1 and `de`=1 in the same cycle: vsync wins. The pixel is still written with `tuser`=1, col/row count it as pixel (0,0), and `sof_pending` ends cleared.
- **Line end:** `tlast` = (`col` == IMG_W-1) at write time.
- **FIFO entry:** {`tuser`, `tlast`, `data`}, 26 bits, first-word-fall-through. The FIFO head drives `VIDEO_OUT_*` directly.
- **Pop:** `tvalid && tready`.
- **Push:** `de`=1, when not full, or when full and a pop occurs in the same cycle (simultaneous push/pop at full is legal and count stays at DEPTH).
- **Full without pop:** the pixel is dropped, `overflow` is set, and the counters still advance so geometry stays aligned.
- **Empty:** `tvalid`=0. `tdata`, `tuser` and `tlast` are don't-care but must hold their last value (no X).
- **AXI stability:** once `tvalid`=1, `tdata`, `tuser` and `tlast` stay stable until `tready`.

## Timing
- **Reset values:** all outputs 0 (`tvalid`, `tuser`, `tlast`, `tdata`, `overflow`, `geom_err`), FIFO empty, counters 0, `sof_pending`=1. The first frame after reset therefore gets `tuser` even without a vsync.
- **Latency:** a pixel sampled with `de` at edge k produces `tvalid`=1 after edge k, i.e. it is visible in cycle k+1 if the FIFO was empty. This is 1 cycle.
- **Throughput:** 1 pixel/cycle in and out.
- **Reset mid-frame:** asserting `aresetn`=0 flushes the FIFO immediately and returns everything to reset values. No partial-line recovery; the next `de` pixel gets `tuser`.
- **Flag clearing:** `overflow` and `geom_err` clear only on reset.

## Configuration
- **With `VIDEO_TO_AXIS_GEOM_CHECK_EN` defined,** `geom_err` is set on any of the following:
  - (a) a `de` 1→0 transition while `col` ≠ 0, i.e. a short line;
  - (b) `vsync` asserted while `row` ≠ 0 or `col` ≠ 0 after at least one pixel of the frame, i.e. a short frame. The first vsync after reset is exempt.
- **Without the macro,** `geom_err` is tied to 0 and the check logic is absent.

## Structure
- **Package `video_axis_pkg`:** `PIX_W`=24, the entry width constant 26, bit positions `USER_BIT`=25 and `LAST_BIT`=24, and a `pix_entry_t` packed struct.
- **Sub-module `axis_fifo_sync`:** parameterized width/depth, FWFT, `count` output, asynchronous active-low reset. Framing logic stays in the top.

## Test plan
- **Basic frame:** reset, then one 64x64 frame with continuous `de` (64 on, 16 off per line), `tready`=1.
  - First output beat has `tuser`=1.
  - `tlast` is on beats 63, 127, ….
  - 4096 beats total, data matches in order, `overflow`=0.
- **Back-pressure:** `tready`=0 for 20 cycles during a line.
  - After 16 pushes the FIFO is full, the next 4 pixels are dropped, and `overflow`=1.
  - When `tready` rises, exactly the 16 buffered beats drain, unchanged while stalled.
- **Full + simultaneous pop:** fill to 16, then `tready`=1 with `de`=1 continuously.
  - No drop, count stays 16, `overflow` stays 0.
- **Vsync mid-frame:** vsync after 10 lines, then a new frame.
  - The next `de` pixel has `tuser`=1, `tlast` realigns at its 64th pixel, and `geom_err`=1 (macro on) / 0 (macro off).
- **Async reset mid-line:** with 5 beats queued, assert `aresetn`=0 for 1 cycle.
  - `tvalid` goes to 0 immediately and all flags are 0.
  - The next `de` pixel gives `tuser`=1.
- **Short line (macro on):** `de` high for 40 cycles only → `geom_err`=1 after the falling edge, with no `tlast` on the 40th pixel.
